// File: rtl/xcheck_pkg.sv
// Shared types and index helpers for the X/Z scan controller and the
// round-robin pointers used by the other sharing schedulers.
package xcheck_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_SCAN   = 2'd2,
        ST_REPORT = 2'd3
    } xcheck_state_e;

    localparam int MAX_SIG = 64;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

    // Wrap-around search for the first unmasked index after cur; cur itself
    // is only returned when it is the sole candidate or everything is masked.
    function automatic int next_unmasked(input int cur, input logic [MAX_SIG-1:0] mask,
                                         input int n);
        int   res;
        int   cand;
        logic found;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k <= MAX_SIG; k++) begin
            if (k <= n) begin
                cand = cur + k;
                if (cand >= n) cand = cand - n;
                if (!found && !mask[cand[5:0]]) begin
                    res   = cand;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/xcheck_rr_pointer.sv
// Registered round-robin index: load wins over advance, otherwise hold.
// Advance skips masked entries and wraps at NUM_SIG-1.
module xcheck_rr_pointer
    import xcheck_pkg::*;
#(
    parameter int NUM_SIG = 8,
    parameter int IW      = idx_w(NUM_SIG)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               advance,
    input  logic [IW-1:0]      load_val,
    input  logic [NUM_SIG-1:0] mask,
    output logic [IW-1:0]      ptr
);

    logic [MAX_SIG-1:0] mask_ext;

    assign mask_ext = MAX_SIG'(mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (advance) begin
            ptr <= IW'(next_unmasked(int'(ptr), mask_ext, NUM_SIG));
        end
    end

endmodule

// File: rtl/xcheck_scan_ctrl.sv
// Time-shares one X/Z detector over NUM_SIG signals, pausing the scan to
// report each unknown over valid/ready and keeping sticky flags and a count.
module xcheck_scan_ctrl
    import xcheck_pkg::*;
#(
    parameter int NUM_SIG = 8,
    parameter int HOLDOFF = 4,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       clr,
    input  logic [NUM_SIG-1:0]         sig_in,
    input  logic [NUM_SIG-1:0]         sig_mask,
    input  logic                       err_ready,
    output logic                       busy,
    output logic [$clog2(NUM_SIG)-1:0] scan_idx,
    output logic                       err_valid,
    output logic [$clog2(NUM_SIG)-1:0] err_idx,
    output logic [CNT_W-1:0]           err_count,
    output logic [NUM_SIG-1:0]         err_sticky
);

    localparam int              IW      = idx_w(NUM_SIG);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    xcheck_state_e      state, state_nxt;
    logic [7:0]         hold_cnt;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      err_idx_r;
    logic [IW-1:0]      first_idx;
    logic [IW-1:0]      resume_idx;
    logic [IW-1:0]      load_val;
    logic [MAX_SIG-1:0] mask_ext;
    logic [NUM_SIG-1:0] hit_bit;
    logic               arm_done;
    logic               det;
    logic               ptr_load;
    logic               ptr_adv;

    assign mask_ext   = MAX_SIG'(sig_mask);
    assign first_idx  = sig_mask[0] ? IW'(next_unmasked(0, mask_ext, NUM_SIG)) : '0;
    assign resume_idx = IW'(next_unmasked(int'(err_idx_r), mask_ext, NUM_SIG));
    assign arm_done   = (hold_cnt <= 8'd1);
    assign hit_bit    = NUM_SIG'(1) << ptr;

    // Masked signals are never sampled, so an X on them cannot raise det.
    assign det      = (state == ST_SCAN) && enable && !sig_mask[ptr] && $isunknown(sig_in[ptr]);
    assign ptr_load = enable && (((state == ST_ARM) && arm_done) ||
                                 ((state == ST_REPORT) && err_ready));
    assign ptr_adv  = (state == ST_SCAN) && enable && !det;
    assign load_val = (state == ST_ARM) ? first_idx : resume_idx;

    xcheck_rr_pointer #(
        .NUM_SIG (NUM_SIG),
        .IW      (IW)
    ) u_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ptr_load),
        .advance  (ptr_adv),
        .load_val (load_val),
        .mask     (sig_mask),
        .ptr      (ptr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   state_nxt = ST_ARM;
                ST_ARM:    if (arm_done) state_nxt = ST_SCAN;
                ST_SCAN:   if (det) state_nxt = ST_REPORT;
                ST_REPORT: if (err_ready) state_nxt = ST_SCAN;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        err_valid = (state == ST_REPORT);
        scan_idx  = ptr;
        err_idx   = err_idx_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if ((state == ST_IDLE) && enable) begin
            hold_cnt <= 8'(HOLDOFF - 1);
        end else if ((state == ST_ARM) && (hold_cnt != 8'd0)) begin
            hold_cnt <= hold_cnt - 8'd1;
        end
    end

    // A clear colliding with a detection leaves only the new error recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_idx_r  <= '0;
            err_count  <= '0;
            err_sticky <= '0;
        end else if (det) begin
            err_idx_r  <= ptr;
            err_count  <= clr ? CNT_W'(1) : sat_inc(err_count);
            err_sticky <= (clr ? '0 : err_sticky) | hit_bit;
        end else if (clr) begin
            err_count  <= '0;
            err_sticky <= '0;
        end
    end

endmodule

// File: doc/xcheck_scan_ctrl.md
Name: xcheck_scan_ctrl

Overview:
- Simulation-side controller that shares one X/Z-detect resource across NUM_SIG monitored single-bit signals.
- Scans the signals round-robin, one per cycle, skipping masked ones.
- On detecting an unknown, pauses the scan and reports it over a valid/ready handshake.
- Keeps a per-signal sticky error map and a saturating error count.
- Sits beside the assertion checkers in the verification environment; it is not a synthesis target.

Parameters:
- NUM_SIG, 8: number of monitored signals (2..64).
- HOLDOFF, 4: cycles after enable rises before the first check (1..255).
- CNT_W, 16: width of the saturating error counter.

Ports:
- clk  input  1  clock; all sampling on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- enable  input  1  run request; level-sensitive.
- clr  input  1  synchronous clear of err_count and err_sticky.
- sig_in  input  NUM_SIG  monitored signals.
- sig_mask  input  NUM_SIG  1 = exclude this signal from scanning.
- err_ready  input  1  consumer accepts the report.
- busy  output  1  high in ARM, SCAN or REPORT.
- scan_idx  output  $clog2(NUM_SIG)  index being checked this cycle.
- err_valid  output  1  report pending.
- err_idx  output  $clog2(NUM_SIG)  index of the reported signal; stable while err_valid.
- err_count  output  CNT_W  total detected errors, saturating.
- err_sticky  output  NUM_SIG  per-signal "has ever been unknown" flags.

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs 0; holdoff counter 0. Reset mid-REPORT drops the report.
- FSM states: IDLE, ARM, SCAN, REPORT.
- IDLE -> ARM: when enable=1. Holdoff counter loads HOLDOFF-1.
- ARM: counter decrements each cycle; at 0 go to SCAN with scan_idx = first unmasked index at or after 0.
- SCAN, per cycle: if sig_in[scan_idx] is unknown ($isunknown) and unmasked:
  - set err_sticky[scan_idx];
  - increment err_count, holding at 2^CNT_W-1;
  - capture err_idx = scan_idx;
  - enter REPORT.
  - err_valid rises the cycle after the sample (latency 1).
- SCAN, no error: scan_idx advances to the next unmasked index, wrapping NUM_SIG-1 -> 0.
- All bits masked: stay in SCAN, scan_idx holds, no checks, no errors.
- REPORT: err_valid=1, scanning paused, scan_idx frozen, err_idx held.
  - On err_valid & err_ready: err_valid drops next cycle and state returns to SCAN.
  - scan_idx resumes at the next unmasked index after err_idx. The erroring signal is not rechecked immediately, which prevents livelock on a stuck X.
- enable low in any non-IDLE state: IDLE next cycle; err_valid drops without handshake; count and sticky retained.
- enable re-assert: full holdoff again.
- clr: zeroes err_count and err_sticky next cycle, in any state.
  - clr and a new detection in the same cycle: clear first, then apply the detection (count=1, only the new bit set).
- sig_mask changes take effect at the next index computation. Masking the currently pending err_idx does not cancel the report.
- Masked signals are never sampled: an X on them is ignored.
- Sampled values of 0/1 are never errors; X and Z both are.

Decomposition:
- Shared package xcheck_pkg:
  - state enum typedef xcheck_state_e;
  - localparam-style function idx_w(n) returning $clog2(n);
  - automatic function next_unmasked(cur, mask) returning the wrap-around search result, or cur if all masked.
- One sub-module xcheck_rr_pointer: registered round-robin index with load, advance and hold controls. Reused by the team's other sharing schedulers.
- Top level holds the FSM, holdoff counter, error counter and sticky bits.

Test Plan:
- Reset and holdoff: NUM_SIG=8, HOLDOFF=4; release rst_n, enable=1 at cycle 0, mask=0 -> busy=1 from cycle 1; scan_idx=0 first at cycle 4; all outputs 0 before that.
- Single X: sig_in[5]=X while scan_idx=5, err_ready=0 -> err_valid=1 next cycle with err_idx=5, err_count=1, err_sticky=8'h20. Hold err_ready=0 for 3 cycles -> scan_idx frozen at 5. Assert err_ready -> scan resumes at 6.
- Mask skip and wrap: mask=8'b1011_0110 -> scan_idx sequence 0,3,6,0,3,...; X on sig_in[1] -> never reported, count stays 0.
- Stuck X with back-to-back ready: sig_in[2]=Z permanently, err_ready=1, mask=0 -> reports at idx 2 once per 9-cycle round (8 scan cycles + 1 REPORT), never consecutive. CNT_W=2 -> count saturates at 3.
- clr collision: clr=1 in the same cycle sig_in[7] is sampled as X, with prior sticky=8'h05 and count=2 -> count=1, sticky=8'h80.
- Abort: deassert enable during REPORT -> err_valid=0 and state IDLE next cycle. Drive rst_n low mid-SCAN -> all outputs 0 immediately, without waiting for a clock edge.
